// File: rtl/fb_plot_writer.sv
// fb_plot_writer
//   Receives plot requests (x, y, colour, plot) from the drawing engines, range-checks them
//   against the canvas, converts (x, y) to a linear framebuffer address, buffers them in a
//   small FIFO and drains them into the shared framebuffer write port through a req/grant
//   handshake with the memory arbiter.
//
// Ports
//   CLOCK_50    in   system clock, rising edge
//   resetn      in   asynchronous active-low reset
//   x, y        in   plot column / row
//   colour      in   plot colour
//   plot        in   plot request, sampled every cycle
//   full        out  FIFO full; plot is ignored while high
//   mem_req     out  request for the framebuffer write port
//   mem_grant   in   arbiter grant, may drop on any cycle
//   mem_addr    out  write address (FIFO head, 0 when empty)
//   mem_data    out  write data (FIFO head, 0 when empty)
//   mem_wren    out  framebuffer write strobe
//   drop_count  out  saturating count of out-of-range plots
//   idle        out  FIFO empty and drain FSM idle
//
// FIFO_DEPTH must be a power of two and at least 2.
module fb_plot_writer #(
   parameter int unsigned H_RES      = 160,
   parameter int unsigned V_RES      = 120,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned ADDR_W     = 15,
   parameter int unsigned COLOR_W    = 3
) (
   input  logic               CLOCK_50,
   input  logic               resetn,
   input  logic [7:0]         x,
   input  logic [6:0]         y,
   input  logic [COLOR_W-1:0] colour,
   input  logic               plot,
   output logic               full,
   output logic               mem_req,
   input  logic               mem_grant,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [COLOR_W-1:0] mem_data,
   output logic               mem_wren,
   output logic [7:0]         drop_count,
   output logic               idle
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {StIdle, StReq, StWrite} state_e;

   // Reset asserts asynchronously but is released in step with the clock.
   logic [1:0] rst_sync_q;
   logic       rst_int_n;

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_int_n = rst_sync_q[1];

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [PTR_W-1:0]   wptr_q, rptr_q;
   logic [7:0]         drop_q;
   logic [ADDR_W-1:0]  addr_mem [FIFO_DEPTH];
   logic [COLOR_W-1:0] data_mem [FIFO_DEPTH];

   logic              in_range;
   logic              accept;
   logic              push;
   logic              pop;
   logic [ADDR_W-1:0] plot_addr;

   assign in_range  = (32'(x) < H_RES) && (32'(y) < V_RES);
   assign accept    = plot && !full;
   assign push      = accept && in_range;
   // y*160 + x as shift-and-add
   assign plot_addr = (ADDR_W'(y) << 7) + (ADDR_W'(y) << 5) + ADDR_W'(x);

   // A write happens only in a granted WRITE cycle; that write retires the head.
   assign pop      = (state_q == StWrite) && mem_grant;
   assign mem_wren = pop;

   assign full = (count_q == CNT_W'(FIFO_DEPTH));
   assign idle = (state_q == StIdle) && (count_q == '0);

   assign mem_addr   = (count_q != '0) ? addr_mem[rptr_q] : '0;
   assign mem_data   = (count_q != '0) ? data_mem[rptr_q] : '0;
   assign drop_count = drop_q;

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (!push && pop) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // Storage carries no reset; occupancy and pointers define what is valid.
   always_ff @(posedge CLOCK_50) begin
      if (push) begin
         addr_mem[wptr_q] <= plot_addr;
         data_mem[wptr_q] <= colour;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge rst_int_n) begin
      if (!rst_int_n) begin
         count_q <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         drop_q  <= '0;
      end else begin
         count_q <= count_d;
         if (push) begin
            wptr_q <= wptr_q + PTR_W'(1);
         end
         if (pop) begin
            rptr_q <= rptr_q + PTR_W'(1);
         end
         if (accept && !in_range && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mem_req = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (count_q != '0) begin
               state_d = StReq;
            end
         end
         StReq: begin
            mem_req = 1'b1;
            if (mem_grant) begin
               state_d = StWrite;
            end
         end
         StWrite: begin
            mem_req = 1'b1;
            if (mem_grant) begin
               // Stay in WRITE for back-to-back writes while entries remain.
               state_d = (count_d != '0) ? StWrite : StIdle;
            end else begin
               state_d = StReq;
            end
         end
         default: state_d = StIdle;
      endcase
   end

endmodule

// File: tb/tb_fb_plot_writer.sv
module tb_fb_plot_writer;

   logic       CLOCK_50;
   logic       resetn;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot;
   logic       full;
   logic       mem_req;
   logic       mem_grant;
   logic [14:0] mem_addr;
   logic [2:0] mem_data;
   logic       mem_wren;
   logic [7:0] drop_count;
   logic       idle;

   fb_plot_writer dut (
      .CLOCK_50  (CLOCK_50),
      .resetn    (resetn),
      .x         (x),
      .y         (y),
      .colour    (colour),
      .plot      (plot),
      .full      (full),
      .mem_req   (mem_req),
      .mem_grant (mem_grant),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .mem_wren  (mem_wren),
      .drop_count(drop_count),
      .idle      (idle)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   int n_checks = 0;
   int n_pass   = 0;
   int n_writes = 0;

   // Expected writes: {addr[14:0], data[2:0]}
   logic [17:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Scoreboard monitor: every observed write pops and compares the oldest expectation.
   always @(negedge CLOCK_50) begin
      if (mem_wren === 1'b1) begin
         n_writes++;
         if (exp_q.size() == 0) begin
            check("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
         end else begin
            logic [17:0] e;
            e = exp_q.pop_front();
            check("wr_addr", 32'(mem_addr), 32'(e[17:3]));
            check("wr_data", 32'(mem_data), 32'(e[2:0]));
         end
      end
   end

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic plot_one(input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc,
                           input bit exp_push, input logic [14:0] exp_addr);
      x      = px;
      y      = py;
      colour = pc;
      plot   = 1'b1;
      @(posedge CLOCK_50);
      #1;
      plot = 1'b0;
      if (exp_push) exp_q.push_back({exp_addr, pc});
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge CLOCK_50);
         if (idle === 1'b1) break;
      end
      check("drain_idle", 32'(idle), 32'd1);
      check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
      check({tag, "_mem_wren"}, 32'(mem_wren), 32'd0);
      check({tag, "_full"}, 32'(full), 32'd0);
      check({tag, "_idle"}, 32'(idle), 32'd1);
      check({tag, "_drop"}, 32'(drop_count), 32'd0);
      check({tag, "_addr"}, 32'(mem_addr), 32'd0);
      check({tag, "_data"}, 32'(mem_data), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

   localparam bit [5:0] T5_GRANT = 6'b111011;  // index 0 = bit 0
   localparam bit [5:0] T5_WREN  = 6'b110010;

   initial begin
      logic [5:0] g_seq;
      logic [5:0] w_seq;
      g_seq = T5_GRANT;
      w_seq = T5_WREN;
      resetn    = 1'b0;
      mem_grant = 1'b0;
      plot      = 1'b0;
      x = '0; y = '0; colour = '0;
      repeat (3) tick();
      @(negedge CLOCK_50);
      check_reset_values("reset");
      tick();
      resetn = 1'b1;
      repeat (4) tick();

      // Single plot, grant held: write two cycles after accept.
      mem_grant = 1'b1;
      plot_one(8'd5, 7'd3, 3'b101, 1'b1, 15'd485);
      @(negedge CLOCK_50);
      check("t1_wren_c0", 32'(mem_wren), 32'd0);
      check("t1_req_c0", 32'(mem_req), 32'd0);
      @(negedge CLOCK_50);
      check("t1_req_c1", 32'(mem_req), 32'd1);
      check("t1_wren_c1", 32'(mem_wren), 32'd0);
      @(negedge CLOCK_50);
      check("t1_wren_c2", 32'(mem_wren), 32'd1);
      check("t1_addr", 32'(mem_addr), 32'd485);
      check("t1_data", 32'(mem_data), 32'd5);
      @(negedge CLOCK_50);
      check("t1_wren_c3", 32'(mem_wren), 32'd0);
      check("t1_idle", 32'(idle), 32'd1);
      tick();

      // Corner plots
      plot_one(8'd0, 7'd0, 3'd2, 1'b1, 15'd0);
      plot_one(8'd159, 7'd119, 3'd7, 1'b1, 15'd19199);
      wait_idle(20);
      tick();

      // Out-of-range plots
      plot_one(8'd160, 7'd0, 3'd1, 1'b0, 15'd0);
      plot_one(8'd0, 7'd120, 3'd1, 1'b0, 15'd0);
      @(negedge CLOCK_50);
      check("t3_drop2", 32'(drop_count), 32'd2);
      check("t3_idle", 32'(idle), 32'd1);
      tick();

      // Fill with grant low
      mem_grant = 1'b0;
      plot_one(8'd1, 7'd1, 3'd1, 1'b1, 15'd161);
      plot_one(8'd2, 7'd1, 3'd2, 1'b1, 15'd162);
      plot_one(8'd3, 7'd1, 3'd3, 1'b1, 15'd163);
      check("t4_full_after3", 32'(full), 32'd0);
      plot_one(8'd4, 7'd1, 3'd4, 1'b1, 15'd164);
      check("t4_full_after4", 32'(full), 32'd1);
      check("t4_req_waiting", 32'(mem_req), 32'd1);
      plot_one(8'd5, 7'd1, 3'd5, 1'b0, 15'd0);
      check("t4_full_after5", 32'(full), 32'd1);
      check("t4_drop_unchanged", 32'(drop_count), 32'd2);
      mem_grant = 1'b1;
      @(negedge CLOCK_50);
      check("t4_wren_req_cycle", 32'(mem_wren), 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge CLOCK_50);
         check("t4_wren_burst", 32'(mem_wren), 32'd1);
      end
      @(negedge CLOCK_50);
      check("t4_wren_after", 32'(mem_wren), 32'd0);
      check("t4_idle", 32'(idle), 32'd1);
      tick();

      // Grant toggling during WRITE
      mem_grant = 1'b0;
      plot_one(8'd10, 7'd10, 3'd1, 1'b1, 15'd1610);
      plot_one(8'd11, 7'd10, 3'd2, 1'b1, 15'd1611);
      plot_one(8'd12, 7'd10, 3'd3, 1'b1, 15'd1612);
      for (int i = 0; i < 6; i++) begin
         mem_grant = g_seq[i];
         @(negedge CLOCK_50);
         check("t5_wren_seq", 32'(mem_wren), 32'(w_seq[i]));
         tick();
      end
      @(negedge CLOCK_50);
      check("t5_idle", 32'(idle), 32'd1);
      check("t5_queue_empty", 32'(exp_q.size()), 32'd0);
      tick();

      // Saturation of drop_count
      for (int i = 0; i < 300; i++) plot_one(8'd200, 7'd100, 3'd0, 1'b0, 15'd0);
      @(negedge CLOCK_50);
      check("t3_drop_sat", 32'(drop_count), 32'd255);
      check("t3_sat_no_req", 32'(mem_req), 32'd0);
      tick();

      // Reset mid-drain: first entry is being written when reset hits.
      mem_grant = 1'b0;
      plot_one(8'd20, 7'd20, 3'd1, 1'b1, 15'd3220);
      plot_one(8'd21, 7'd20, 3'd2, 1'b0, 15'd0);
      plot_one(8'd22, 7'd20, 3'd3, 1'b0, 15'd0);
      mem_grant = 1'b1;
      @(negedge CLOCK_50);
      @(negedge CLOCK_50);
      check("t6_wren_before_reset", 32'(mem_wren), 32'd1);
      #1 resetn = 1'b0;
      #1;
      check_reset_values("t6_async");
      repeat (2) tick();
      resetn = 1'b1;
      repeat (8) tick();
      @(negedge CLOCK_50);
      check("t6_req_after", 32'(mem_req), 32'd0);
      check("t6_idle_after", 32'(idle), 32'd1);
      check("total_writes", 32'(n_writes), 32'd11);
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
